// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, counter width, FSM state encoding and
// a small window-decode helper used by the sync generator.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DIV_DEF    = 4;
    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    localparam int unsigned H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    // 1 when lo <= c < hi
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: counts 0..DIV-1 while en is high, held at 0 otherwise.
// Ports: clk_in, reset (async active-low), en (count enable),
//        tick_c (combinational: this cycle is the last of a pixel period),
//        tick (tick_c registered, one cycle later).
module pix_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    output logic tick_c,
    output logic tick
);

    localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // With DIV=1 the counter never leaves 0, so every enabled cycle ticks
    assign tick_c = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= tick_c;
            if (!en || tick_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer: run/stop FSM, h/v counters advanced on the pixel tick,
// and registered sync/blank/coordinate decode.
// Ports: clk_in, reset (async active-low), run_req (level start/stop request),
//        running, pix_tick, hsync, vsync, video_on, x, y, frame_start.
// All outputs are registered one clock behind the internal counter state, so
// x/y/syncs change the clock after the pix_tick that advanced them.
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned DIV      = DIV_DEF,
    parameter int unsigned H_VIS    = H_VIS_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_VIS    = V_VIS_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run_req,
    output logic             running,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    state_t           state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             run_en;
    logic             tick_c;
    logic             line_end;
    logic             frame_end;

    assign run_en    = (state != ST_IDLE);
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = tick_c && line_end && (v_cnt == V_LAST);

    pix_tick_gen #(.DIV(DIV)) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (run_en),
        .tick_c (tick_c),
        .tick   (pix_tick)
    );

    // FSM, raster counters and registered output decode
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            running     <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            x           <= '0;
            y           <= '0;
        end else begin
            running     <= run_en;
            video_on    <= run_en && (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
            hsync       <= in_window(h_cnt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= in_window(v_cnt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            x           <= h_cnt;
            y           <= v_cnt;
            // Strobe with the tick taken at the origin; a pending stop suppresses it
            frame_start <= tick_c && (state == ST_RUN) && (h_cnt == '0) && (v_cnt == '0);

            if (state == ST_IDLE) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (tick_c) begin
                if (line_end) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end

            case (state)
                ST_IDLE:      if (run_req) state <= ST_RUN;
                ST_RUN:       if (!run_req) state <= ST_STOP_PEND;
                ST_STOP_PEND: begin
                    // Stop only lands on the tick that closes the frame
                    if (run_req)        state <= ST_RUN;
                    else if (frame_end) state <= ST_IDLE;
                end
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule
